adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 1000, giving the number of test vectors per run; legal range 1..65535.
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR start value; it SHALL be non-zero.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port start, input, 1 bit: one-cycle run request.
REQ-006 Port a_out, output, 1 bit: operand a driven to the 1-bit adder under test.
REQ-007 Port b_out, output, 1 bit: operand b driven to the adder under test.
REQ-008 Port sum_in, input, 1 bit: sum returned combinationally by the adder under test.
REQ-009 Port busy, output, 1 bit: high while a run is in progress.
REQ-010 Port done, output, 1 bit: high from run completion until the next start or reset.
REQ-011 Port pass, output, 1 bit: high only when done=1 and fail_cnt=0.
REQ-012 Port fail_cnt, output, 16 bits: number of mismatching vectors in the current or last run.
REQ-013 Port first_fail_idx, output, 16 bits: index (0-based) of the first mismatching vector; 16'hFFFF when none.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 goes to DRIVE.
- DRIVE: always goes to CHECK.
- CHECK: goes to DRIVE if vec_idx < NUM_VECTORS-1, else to DONE.
- DONE: start=1 goes to DRIVE; otherwise holds.
REQ-015 On each accepted start (IDLE or DONE), the block SHALL, on the same edge, load the LFSR with SEED, clear vec_idx and fail_cnt, and set first_fail_idx to 16'hFFFF.
REQ-016 The LFSR SHALL be 16-bit Fibonacci with polynomial x^16+x^14+x^13+x^11+1 (feedback = l[15]^l[13]^l[12]^l[10]), shifting left with feedback into bit 0.
REQ-017 a_out SHALL equal lfsr[0] and b_out SHALL equal lfsr[1], both directly from the register with no combinational path from inputs.
REQ-018 Operands SHALL be stable through DRIVE and CHECK of a vector, and change only on the CHECK->DRIVE edge.
REQ-019 sum_in SHALL be sampled only in CHECK; expected = a_out XOR b_out (A+B truncated to 1 bit).
REQ-020 On a CHECK mismatch, fail_cnt SHALL increment by 1. If first_fail_idx=16'hFFFF, it SHALL load vec_idx.
REQ-021 On leaving CHECK, the LFSR SHALL advance once and vec_idx SHALL increment; vec_idx SHALL NOT advance on the CHECK->DONE edge.
REQ-022 A run SHALL take exactly 2*NUM_VECTORS cycles with busy=1; done SHALL rise on the edge after the last CHECK.
REQ-023 start while busy=1 SHALL be ignored, with no effect on state, counters or LFSR.
REQ-024 busy and done SHALL never be high together; pass SHALL equal done AND (fail_cnt==0).
REQ-025 sum_in SHALL be ignored in IDLE, DRIVE and DONE.

Reset
REQ-026 rst=1 SHALL take priority over start at any time, including mid-run, and SHALL force the following on the next edge:
- state IDLE, lfsr=SEED, vec_idx=0;
- busy=0, done=0, pass=0, fail_cnt=0;
- first_fail_idx=16'hFFFF.
REQ-027 After reset, a_out=1 and b_out=0 (SEED bits 0 and 1) SHALL be held until a run advances the LFSR.

Verification
REQ-028 Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, pass=0, fail_cnt=0, first_fail_idx=16'hFFFF, a_out=1, b_out=0.
REQ-029 Correct DUT (sum_in=a_out^b_out), NUM_VECTORS=4, pulse start -> busy=1 for 8 cycles, then done=1, pass=1, fail_cnt=0, first_fail_idx=16'hFFFF.
REQ-030 sum_in stuck at 0, NUM_VECTORS=4 -> first_fail_idx=0 (vector 0 is a=1, b=0), fail_cnt equals the reference-model count of a^b=1 over 4 vectors, pass=0.
REQ-031 Pulse start again in cycle 3 of a run -> ignored; run still ends after 8 busy cycles with identical results.
REQ-032 Assert rst in cycle 5 of a run -> next cycle IDLE, busy=0, fail_cnt=0; a subsequent start completes normally.
REQ-033 Restart from DONE with a faulty DUT, NUM_VECTORS=1000 -> operand sequence identical to the first run (same SEED) and fail_cnt identical across both runs; the checker's fail_cnt matches the bench model exactly.

Source files
------------

// File: rtl/adder_bist.sv
// Built-in self-test controller for a 1-bit adder: drives LFSR operands, checks the
// returned sum against a XOR b, and records the mismatch count and first failing index.
module adder_bist #(
    parameter int unsigned NUM_VECTORS = 1000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a_out,
    output logic        b_out,
    input  logic        sum_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_cnt,
    output logic [15:0] first_fail_idx
);

    if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
        $error("NUM_VECTORS must be in 1..65535");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("SEED must be non-zero");
    end

    localparam logic [15:0] LastIdx = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] NoFail  = 16'hFFFF;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] vec_q, vec_d;
    logic [15:0] fail_q, fail_d;
    logic [15:0] first_q, first_d;
    logic        feedback;
    logic        mismatch;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign mismatch = sum_in != (lfsr_q[0] ^ lfsr_q[1]);

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        vec_d   = vec_q;
        fail_d  = fail_q;
        first_d = first_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StDrive;
                    lfsr_d  = SEED;
                    vec_d   = '0;
                    fail_d  = '0;
                    first_d = NoFail;
                end
            end
            StDrive: begin
                state_d = StCheck;
            end
            StCheck: begin
                // sum_in is only trusted here, after a full DRIVE cycle of settled operands
                if (mismatch) begin
                    fail_d = fail_q + 16'd1;
                    if (first_q == NoFail) begin
                        first_d = vec_q;
                    end
                end
                lfsr_d = {lfsr_q[14:0], feedback};
                if (vec_q < LastIdx) begin
                    vec_d   = vec_q + 16'd1;
                    state_d = StDrive;
                end else begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset taking priority over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            vec_q   <= '0;
            fail_q  <= '0;
            first_q <= NoFail;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        a_out          = lfsr_q[0];
        b_out          = lfsr_q[1];
        busy           = (state_q == StDrive) || (state_q == StCheck);
        done           = (state_q == StDone);
        pass           = (state_q == StDone) && (fail_q == 16'd0);
        fail_cnt       = fail_q;
        first_fail_idx = first_q;
    end

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench for adder_bist: two instances (4 and 1000 vectors) share reset,
// one is selected at a time; a fault model plays the adder under test.
module tb_adder_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic start = 1'b0;
    logic sel   = 1'b0;
    int   mode  = 0;  // 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 OR instead of XOR

    function automatic logic fault_sum(int m, logic a, logic b);
        case (m)
            0:       return logic'((int'(a) + int'(b)) % 2);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return a | b;
        endcase
    endfunction

    logic        a4, b4, s4, busy4, done4, pass4;
    logic [15:0] fc4, ff4;
    logic        a1k, b1k, s1k, busy1k, done1k, pass1k;
    logic [15:0] fc1k, ff1k;
    logic        start4, start1k;

    assign start4  = start & ~sel;
    assign start1k = start & sel;
    assign s4      = fault_sum(mode, a4, b4);
    assign s1k     = fault_sum(mode, a1k, b1k);

    adder_bist #(.NUM_VECTORS(4), .SEED(16'hACE1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_out(a4), .b_out(b4), .sum_in(s4),
        .busy(busy4), .done(done4), .pass(pass4), .fail_cnt(fc4), .first_fail_idx(ff4)
    );

    adder_bist #(.NUM_VECTORS(1000), .SEED(16'hACE1)) dut1k (
        .clk(clk), .rst(rst), .start(start1k), .a_out(a1k), .b_out(b1k), .sum_in(s1k),
        .busy(busy1k), .done(done1k), .pass(pass1k), .fail_cnt(fc1k), .first_fail_idx(ff1k)
    );

    logic        m_a, m_b, m_busy, m_done, m_pass;
    logic [15:0] m_fail, m_first;
    assign m_a     = sel ? a1k : a4;
    assign m_b     = sel ? b1k : b4;
    assign m_busy  = sel ? busy1k : busy4;
    assign m_done  = sel ? done1k : done4;
    assign m_pass  = sel ? pass1k : pass4;
    assign m_fail  = sel ? fc1k : fc4;
    assign m_first = sel ? ff1k : ff4;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        int          n;
        int          fails;
        logic [15:0] first;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] ops_q[$];

    // Reference model: walk the operand sequence and tally where the faulty adder
    // disagrees with the true 1-bit sum, then pulse start.
    task automatic issue_run(input int n);
        exp_t        e;
        logic [15:0] l;
        logic        a, b, good;
        l       = 16'hACE1;
        e.n     = n;
        e.fails = 0;
        e.first = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            a    = l[0];
            b    = l[1];
            good = logic'((int'(a) + int'(b)) % 2);
            ops_q.push_back({a, b});
            if (fault_sum(mode, a, b) != good) begin
                e.fails++;
                if (e.first == 16'hFFFF) e.first = 16'(i);
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!m_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!m_done) chk("done_timeout", 32'(m_done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: follows each run on the selected instance and scores it at completion
    bit          in_run    = 1'b0;
    int          busy_cyc  = 0;
    int          exp_left  = 0;
    logic [1:0]  cur_op    = 2'b00;
    logic [15:0] last_fail = '0;
    exp_t        got_e;

    always @(negedge clk) begin
        if (rst) begin
            if (in_run) begin
                for (int i = 0; i < exp_left; i++) void'(ops_q.pop_front());
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            in_run = 1'b0;
        end else begin
            if (!in_run && m_busy) begin
                in_run   = 1'b1;
                busy_cyc = 0;
                exp_left = (exp_q.size() > 0) ? exp_q[0].n : 0;
            end
            if (in_run) begin
                if (m_busy) begin
                    busy_cyc++;
                    if (busy_cyc % 2 == 1 && ops_q.size() > 0) begin
                        cur_op = ops_q.pop_front();
                        exp_left--;
                    end
                    chk("operands", 32'({m_a, m_b}), 32'(cur_op));
                    chk("busy_done_exclusive", 32'(m_done), 32'd0);
                end else begin
                    in_run = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_run", 32'd1, 32'd0);
                    end else begin
                        got_e = exp_q.pop_front();
                        chk("busy_cycles", 32'(busy_cyc), 32'(2 * got_e.n));
                        chk("done", 32'(m_done), 32'd1);
                        chk("pass", 32'(m_pass), 32'(got_e.fails == 0));
                        chk("fail_cnt", 32'(m_fail), 32'(got_e.fails));
                        chk("first_fail_idx", 32'(m_first), 32'(got_e.first));
                    end
                    last_fail = m_fail;
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] f1;
        int          gap;

        // Reset held two cycles with start asserted
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_pass", 32'(pass4), 32'd0);
        chk("rst_fail_cnt", 32'(fc4), 32'd0);
        chk("rst_first_fail", 32'(ff4), 32'hFFFF);
        chk("rst_a_out", 32'(a4), 32'd1);
        chk("rst_b_out", 32'(b4), 32'd0);
        chk("rst_busy_1k", 32'(busy1k), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Correct adder, then stuck-at-0
        mode = 0;
        issue_run(4);
        wait_done(40);
        mode = 1;
        issue_run(4);
        wait_done(40);
        chk("stuck0_first_fail", 32'(m_first), 32'd0);

        // Start pulse during a run is ignored
        mode = 3;
        issue_run(4);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40);

        // Randomized runs, some restarted straight from DONE, some with stray starts
        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            #1;
            issue_run(4);
            if ($urandom_range(0, 1) == 1) begin
                repeat (int'($urandom_range(0, 4))) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_done(40);
        end

        // Reset mid-run aborts, then a fresh run completes
        mode = 1;
        issue_run(4);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_done", 32'(m_done), 32'd0);
        chk("abort_fail_cnt", 32'(m_fail), 32'd0);
        chk("abort_first_fail", 32'(m_first), 32'hFFFF);
        @(posedge clk);
        #1;
        issue_run(4);
        wait_done(40);

        // Long run with a faulty adder, restarted from DONE
        sel  = 1'b1;
        mode = 3;
        @(posedge clk);
        #1;
        issue_run(1000);
        wait_done(2100);
        f1 = last_fail;
        issue_run(1000);
        wait_done(2100);
        chk("restart_fail_cnt_same", 32'(last_fail), 32'(f1));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
